// File: rtl/fasta_pkg.sv
// Shared definitions for the FASTA base packer: 2-bit base codes,
// the ASCII bytes that steer parsing, and the packer FSM states.
package fasta_pkg;

    // 2-bit nucleotide codes; invalid symbols also pack as BASE_A
    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    // ASCII bytes with special meaning in the sequence stream
    localparam logic [7:0] CH_GT  = 8'h3E;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_NUL = 8'h00;

    // Packer job phases
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fasta_base_packer_base_encode.sv
// Combinational classifier for one source byte: tells the packer whether
// the byte is a base, an invalid symbol, a line break, a header marker or
// the terminator, and gives the 2-bit code to pack.
module base_encode
    import fasta_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       is_base,
    output logic       is_invalid,
    output logic       is_skip,
    output logic       is_hdr,
    output logic       is_term,
    output logic [1:0] code
);

    // Decode the byte into exactly one class; anything unrecognised is invalid
    always_comb begin
        is_base    = 1'b0;
        is_invalid = 1'b0;
        is_skip    = 1'b0;
        is_hdr     = 1'b0;
        is_term    = 1'b0;
        code       = BASE_A;
        case (byte_in)
            CH_NUL:        is_term = 1'b1;
            CH_LF, CH_CR:  is_skip = 1'b1;
            CH_GT:         is_hdr  = 1'b1;
            8'h41, 8'h61: begin
                is_base = 1'b1;
                code    = BASE_A;
            end
            8'h43, 8'h63: begin
                is_base = 1'b1;
                code    = BASE_C;
            end
            8'h47, 8'h67: begin
                is_base = 1'b1;
                code    = BASE_G;
            end
            8'h54, 8'h74: begin
                is_base = 1'b1;
                code    = BASE_T;
            end
            default: begin
                is_invalid = 1'b1;
                code       = BASE_A;
            end
        endcase
    end

endmodule

// File: rtl/fasta_base_packer.sv
// Reads ASCII sequence bytes from a synchronous-read source RAM, drops
// FASTA header lines and line breaks, and packs four 2-bit base codes per
// byte into a destination RAM (first base in the LSBs). Also counts packed
// symbols and how many of them were not A/C/G/T.
module fasta_base_packer
    import fasta_pkg::*;
#(
    parameter int ADDR_WIDTH     = 15,
    parameter int DST_ADDR_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH:0]       len,
    output logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [7:0]                src_data,
    output logic [DST_ADDR_WIDTH-1:0] dst_addr,
    output logic [7:0]                dst_data,
    output logic                      dst_we,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH:0]       base_count,
    output logic [ADDR_WIDTH:0]       invalid_count
);

    localparam logic [ADDR_WIDTH:0]       CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]       CNT_MAX = {(ADDR_WIDTH+1){1'b1}};
    localparam logic [DST_ADDR_WIDTH-1:0] DST_ONE = {{(DST_ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH:0]       len_q;
    logic [ADDR_WIDTH:0]       issued;
    logic                      rd_valid;
    logic                      hdr_flag;
    logic [7:0]                acc;
    logic [1:0]                pend;
    logic [DST_ADDR_WIDTH-1:0] wr_idx;

    logic       enc_base;
    logic       enc_invalid;
    logic       enc_skip;
    logic       enc_hdr;
    logic       enc_term;
    logic [1:0] enc_code;

    logic start_ok;
    logic in_read;
    logic issue;
    logic byte_ok;
    logic term_hit;
    logic last_byte;
    logic take_sym;
    logic full_byte;
    logic flush_wr;

    base_encode u_encode (
        .byte_in    (src_data),
        .is_base    (enc_base),
        .is_invalid (enc_invalid),
        .is_skip    (enc_skip),
        .is_hdr     (enc_hdr),
        .is_term    (enc_term),
        .code       (enc_code)
    );

    assign src_addr = issued[ADDR_WIDTH-1:0];

    // Per-cycle qualifiers: what the read pipeline and packer do this cycle
    always_comb begin
        start_ok  = (state == ST_IDLE) && start;
        in_read   = (state == ST_READ);
        issue     = in_read && (issued != len_q);
        byte_ok   = in_read && rd_valid;
        term_hit  = byte_ok && enc_term;
        last_byte = byte_ok && (issued == len_q);
        take_sym  = byte_ok && !hdr_flag && (enc_base || enc_invalid);
        full_byte = take_sym && (pend == 2'd3);
        flush_wr  = (state == ST_FLUSH) && (pend != 2'd0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a terminator or the last requested byte ends the read phase
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (term_hit || last_byte) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_READ, ST_FLUSH: busy = 1'b1;
            ST_DONE:           done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Read address generator; rd_valid marks the byte returning one cycle later,
    // and leaving READ drops any byte still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            issued   <= '0;
            rd_valid <= 1'b0;
        end else if (start_ok) begin
            len_q    <= len;
            issued   <= '0;
            rd_valid <= 1'b0;
        end else if (in_read && !term_hit && !last_byte) begin
            rd_valid <= issue;
            if (issue) begin
                issued <= issued + CNT_ONE;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

    // Header flag: set by '>' and cleared by the line break that ends the header
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_flag <= 1'b0;
        end else if (start_ok) begin
            hdr_flag <= 1'b0;
        end else if (byte_ok && !enc_term) begin
            if (enc_skip) begin
                hdr_flag <= 1'b0;
            end else if (enc_hdr) begin
                hdr_flag <= 1'b1;
            end
        end
    end

    // Base accumulator; empties on the 4th base so packing never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            pend <= '0;
        end else if (start_ok || flush_wr) begin
            acc  <= '0;
            pend <= '0;
        end else if (take_sym) begin
            if (pend == 2'd3) begin
                acc  <= '0;
                pend <= 2'd0;
            end else begin
                acc[{pend, 1'b0} +: 2] <= enc_code;
                pend                   <= pend + 2'd1;
            end
        end
    end

    // Registered destination write port; byte index restarts at 0 per job and wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_we   <= 1'b0;
            dst_data <= '0;
            dst_addr <= '0;
            wr_idx   <= '0;
        end else begin
            dst_we <= full_byte || flush_wr;
            if (start_ok) begin
                wr_idx <= '0;
            end else if (full_byte || flush_wr) begin
                dst_data <= full_byte ? {enc_code, acc[5:0]} : acc;
                dst_addr <= wr_idx;
                wr_idx   <= wr_idx + DST_ONE;
            end
        end
    end

    // Saturating symbol counters, held after the job ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_count    <= '0;
            invalid_count <= '0;
        end else if (start_ok) begin
            base_count    <= '0;
            invalid_count <= '0;
        end else if (take_sym) begin
            if (base_count != CNT_MAX) begin
                base_count <= base_count + CNT_ONE;
            end
            if (enc_invalid && (invalid_count != CNT_MAX)) begin
                invalid_count <= invalid_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fasta_base_packer.sv
// Self-checking bench for fasta_base_packer: directed FASTA snippets plus
// random byte streams, compared against a string-level packing model.
module tb_fasta_base_packer;

    localparam int AW = 15;
    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] src_addr;
    logic [7:0]    src_data = '0;
    logic [DW-1:0] dst_addr;
    logic [7:0]    dst_data;
    logic          dst_we;
    logic          busy;
    logic          done;
    logic [AW:0]   base_count;
    logic [AW:0]   invalid_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cyc = 0;

    logic [7:0] mem [0:(1<<AW)-1];

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;
    wr_t wr_q[$];

    fasta_base_packer #(.ADDR_WIDTH(AW), .DST_ADDR_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .len           (len),
        .src_addr      (src_addr),
        .src_data      (src_data),
        .dst_addr      (dst_addr),
        .dst_data      (dst_data),
        .dst_we        (dst_we),
        .busy          (busy),
        .done          (done),
        .base_count    (base_count),
        .invalid_count (invalid_count)
    );

    always #5 clk = ~clk;

    // Source RAM with one-cycle synchronous read
    always @(posedge clk) src_data <= mem[src_addr];

    always @(posedge clk) cyc = cyc + 1;

    // Destination write capture
    always @(negedge clk) begin
        if (dst_we) wr_q.push_back('{int'(dst_addr), int'(dst_data), cyc});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadString(input string s);
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    endtask

    // Runs one job of n bytes and checks it against the reference model
    task automatic applyStimulus(input string tag, input int n, input bit inject);
        logic [1:0] cq[$];
        logic [7:0] exp_q[$];
        int         exp_inv;
        bit         hdr;
        bit         seen;
        logic [7:0] b;
        logic [7:0] v;

        exp_inv = 0;
        hdr = 0;
        for (int i = 0; i < n; i++) begin
            b = mem[i];
            if (b == 8'h00) break;
            if (b == 8'h0A || b == 8'h0D) begin
                hdr = 0;
                continue;
            end
            if (hdr) continue;
            if (b == ">") begin
                hdr = 1;
                continue;
            end
            case (b)
                "A", "a": cq.push_back(2'd0);
                "C", "c": cq.push_back(2'd1);
                "G", "g": cq.push_back(2'd2);
                "T", "t": cq.push_back(2'd3);
                default: begin
                    cq.push_back(2'd0);
                    exp_inv++;
                end
            endcase
        end
        for (int k = 0; k < cq.size(); k += 4) begin
            v = 8'h00;
            for (int j = 0; j < 4; j++) begin
                if (k + j < cq.size()) v = v | (8'(cq[k+j]) << (2 * j));
            end
            exp_q.push_back(v);
        end

        wr_q.delete();
        seen = 0;
        @(negedge clk);
        start = 1'b1;
        len = (AW+1)'(n);
        for (int c = 0; c < n + 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                break;
            end
            if (inject && c == 2) begin
                start = 1'b1;
                len = (AW+1)'(n + 3);
            end
        end
        start = 1'b0;
        #1;
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        checkOutput({tag, "_base_count"}, 32'(base_count), 32'(cq.size()));
        checkOutput({tag, "_invalid_count"}, 32'(invalid_count), 32'(exp_inv));
        checkOutput({tag, "_write_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wr_q[i].a), 32'(i % (1 << DW)));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(wr_q[i].d), 32'(exp_q[i]));
        end
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_count_held"}, 32'(base_count), 32'(cq.size()));
    endtask

    initial begin
        string alpha;
        int    n;
        int    r;

        alpha = "ACGTacgtNnX>\n\r";
        for (int i = 0; i < 256; i++) mem[i] = 8'h41;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_dst_we", 32'(dst_we), 32'd0);
        checkOutput("reset_base_count", 32'(base_count), 32'd0);
        checkOutput("reset_src_addr", 32'(src_addr), 32'd0);
        rst_n = 1'b1;

        loadString("ACGT");
        applyStimulus("acgt", 4, 0);
        if (wr_q.size() > 0) checkOutput("acgt_done_after_write", 32'(done_cyc - wr_q[0].c), 32'd1);

        loadString("ACGxTTTT");
        mem[3] = 8'h00;
        applyStimulus("term", 8, 0);

        loadString(">x1\nAC\nGT\n");
        applyStimulus("header", 10, 0);

        loadString("aNgtACGT");
        applyStimulus("invalid", 8, 0);
        if (wr_q.size() == 2) checkOutput("invalid_no_gap", 32'(wr_q[1].c - wr_q[0].c), 32'd4);

        applyStimulus("len0", 0, 0);
        checkOutput("len0_latency", 32'(wr_q.size()), 32'd0);

        loadString("GATTACACAT");
        applyStimulus("midstart", 10, 1);

        // Reset in the middle of a job, after two bases have been taken in
        loadString("ACGTACGT");
        wr_q.delete();
        @(negedge clk);
        start = 1'b1;
        len = (AW+1)'(8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_dst_we", 32'(dst_we), 32'd0);
        checkOutput("rst_base_count", 32'(base_count), 32'd0);
        checkOutput("rst_src_addr", 32'(src_addr), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("rst_no_writes", 32'(wr_q.size()), 32'd0);
        rst_n = 1'b1;
        loadString("ACGT");
        applyStimulus("after_rst", 4, 0);

        // Random byte streams
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 60);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 99);
                if (r < 2) mem[i] = 8'h00;
                else if (r < 8) mem[i] = 8'($urandom_range(1, 255));
                else mem[i] = alpha[$urandom_range(0, alpha.len() - 1)];
            end
            applyStimulus($sformatf("rnd%0d", t), n, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fasta_base_packer.md
Name: fasta_base_packer

Overview:
- Downstream of fasta_to_sam_fsm: reads the ASCII sequence bytes it left in block RAM (synchronous read, 1-cycle latency).
- Strips FASTA headers and line breaks, maps bases to 2-bit codes and packs 4 bases per byte into a destination RAM.
- Reports base and invalid-symbol counts for the compressed sequence store.

Parameters:
- ADDR_WIDTH, 15, source RAM address width.
- DST_ADDR_WIDTH, 13, destination RAM address width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  1-cycle pulse; begins a job when idle.
- len  in  ADDR_WIDTH+1  source bytes to scan; sampled on start.
- src_addr  out  ADDR_WIDTH  source RAM address.
- src_data  in  8  source RAM read data, valid 1 cycle after src_addr.
- dst_addr  out  DST_ADDR_WIDTH  destination byte address.
- dst_data  out  8  packed byte.
- dst_we  out  1  destination write strobe.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse at job end.
- base_count  out  ADDR_WIDTH+1  bases packed, including invalid symbols; held after done.
- invalid_count  out  ADDR_WIDTH+1  non-ACGT symbols packed as code 00.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; accumulator, counters and header flag cleared.
- States:
  - IDLE: start=1 and len>0 -> READ; clear counters; src_addr=0. start=1 and len=0 -> DONE with no writes.
  - READ: present src_addr, increment it each cycle until len addresses have been issued. A 1-cycle-delayed valid flag qualifies src_data, giving 1 byte/clk throughput. When the last data byte is processed, go to FLUSH.
  - FLUSH: if 1-3 bases are pending, write the zero-padded byte; then go to DONE.
  - DONE: done=1 and busy=0 for one cycle; then go to IDLE.
- Byte classification (applies only to valid src_data):
  - 0x00: terminator. Stops issuing reads; any in-flight byte is discarded; go to FLUSH.
  - 0x0A or 0x0D: skipped; clears the header flag.
  - '>' (0x3E): sets the header flag. All bytes are skipped while the flag is set.
  - A/a=00, C/c=01, G/g=10, T/t=11.
  - Any other byte: code 00, invalid_count+1.
- Every packed symbol increments base_count.
- Packing order: base k of a byte goes to bits [2k+1:2k]; the first base is in the LSBs.
- On the 4th base, the registered write occurs the next cycle: dst_we=1, dst_data=byte, dst_addr=packed-byte index starting at 0. The accumulator clears simultaneously, so there are no stalls.
- dst_addr wraps modulo 2^DST_ADDR_WIDTH; no error is flagged.
- start while busy is ignored.
- Async reset mid-job: abort immediately; no flush write; no done pulse.
- Counters saturate at all-ones.

Decomposition:
- Shared package fasta_pkg:
  - Base code constants BASE_A/C/G/T.
  - ASCII constants CH_GT, CH_LF, CH_CR, CH_NUL.
  - FSM state enum.
- One natural sub-module, base_encode: combinational byte -> {is_base, is_invalid, is_skip, is_hdr, is_term, code[1:0]}. Instantiated once.

Test Plan:
- RAM "ACGT", len=4 -> one write dst[0]=0xE4; base_count=4, invalid_count=0; done 1 cycle after the write cycle.
- "ACG", 0x00, "TTTT", len=8 -> single write dst[0]=0x24 (flush); base_count=3; bytes after the terminator are never written.
- ">x1\nAC\nGT\n", len=10 -> dst[0]=0xE4; base_count=4; no writes caused by header bytes.
- "aNgtACGT", len=8 -> dst[0]=0xE0, dst[1]=0xE4; invalid_count=1; base_count=8; writes occur on consecutive-byte throughput with no gaps.
- len=0 start -> done next cycle; no dst_we. A start pulse mid-job is ignored and base_count is unchanged.
- Assert rst_n low mid-job after 2 bases -> all outputs 0 asynchronously; no flush write; a new start after release packs "ACGT" to dst[0]=0xE4.
